binary_multiplier_4bit: RTL and testbench



---
 rtl/binary_multiplier_4bit_pkg.sv | 19 +
 rtl/binary_multiplier_4bit_adder.sv | 15 +
 rtl/binary_multiplier_4bit.sv | 111 +++++++++++
 tb/tb_binary_multiplier_4bit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/binary_multiplier_4bit_pkg.sv
// Shared definitions for the 4-bit shift-add multiplier: controller state
// encodings, operand/product widths and the add/shift step count.
package binary_multiplier_4bit_pkg;

  localparam int OPER_W = 4;
  localparam int PROD_W = 8;
  localparam int CNT_W  = 3;

  // Number of add/shift pairs per multiplication (one per multiplier bit).
  localparam logic [CNT_W-1:0] MULT_STEPS = 3'd4;

  // Encoding 2'b11 is intentionally unused; the controller recovers to S_idle.
  typedef enum logic [1:0] {
    S_idle  = 2'b00,
    S_add   = 2'b01,
    S_shift = 2'b10
  } mult_state_t;

endpackage

// File: rtl/binary_multiplier_4bit_adder.sv
// 4-bit dataflow ripple adder (binary_adder_4bit_df) feeding the multiplier
// accumulator; purely combinational.
module binary_adder_4bit_df
  import binary_multiplier_4bit_pkg::*;
(
  input  logic [OPER_W-1:0] a,
  input  logic [OPER_W-1:0] b,
  input  logic              cin,
  output logic [OPER_W-1:0] sum,
  output logic              carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/binary_multiplier_4bit.sv
// Sequential 4x4 unsigned shift-add multiplier, 8 cycles per product.
// Optional MULT_DONE_PULSE_EN adds a one-cycle registered Done pulse.
module binary_multiplier_4bit
  import binary_multiplier_4bit_pkg::*;
(
  input  logic              clock,
  input  logic              reset_b,
  input  logic              Start,
  input  logic [OPER_W-1:0] Multiplicand,
  input  logic [OPER_W-1:0] Multiplier,
  output logic [PROD_W-1:0] Product,
  output logic              Ready
`ifdef MULT_DONE_PULSE_EN
  ,
  output logic              Done
`endif
);

  mult_state_t       state_r;
  logic [OPER_W-1:0] a_r;
  logic [OPER_W-1:0] q_r;
  logic [OPER_W-1:0] b_r;
  logic              c_r;
  logic [CNT_W-1:0]  p_r;
  logic              ready_r;
  logic [OPER_W-1:0] sum_s;
  logic              carry_s;

  binary_adder_4bit_df u_adder (
    .a     (a_r),
    .b     (b_r),
    .cin   (1'b0),
    .sum   (sum_s),
    .carry (carry_s)
  );

  // Controller and datapath registers; Ready is registered alongside the state.
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      state_r <= S_idle;
      a_r     <= 4'h0;
      q_r     <= 4'h0;
      b_r     <= 4'h0;
      c_r     <= 1'b0;
      p_r     <= 3'd0;
      ready_r <= 1'b1;
    end else begin
      case (state_r)
        S_idle: begin
          if (Start) begin
            b_r     <= Multiplicand;
            q_r     <= Multiplier;
            a_r     <= 4'h0;
            c_r     <= 1'b0;
            p_r     <= MULT_STEPS;
            state_r <= S_add;
            ready_r <= 1'b0;
          end else begin
            ready_r <= 1'b1;
          end
        end
        S_add: begin
          p_r <= p_r - 3'd1;
          if (q_r[0]) begin
            a_r <= sum_s;
            c_r <= carry_s;
          end else begin
            a_r <= a_r;
            c_r <= c_r;
          end
          state_r <= S_shift;
          ready_r <= 1'b0;
        end
        S_shift: begin
          // Logical right shift of the 9-bit {C,A,Q} concatenation.
          {c_r, a_r, q_r} <= {1'b0, c_r, a_r, q_r[3:1]};
          if (p_r == 3'd0) begin
            state_r <= S_idle;
            ready_r <= 1'b1;
          end else begin
            state_r <= S_add;
            ready_r <= 1'b0;
          end
        end
        default: begin
          state_r <= S_idle;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign Product = {a_r, q_r};
  assign Ready   = ready_r;

`ifdef MULT_DONE_PULSE_EN
  logic done_r;

  // Done fires on the cycle after the final shift, coincident with Ready rising.
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r == S_shift) && (p_r == 3'd0);
    end
  end

  assign Done = done_r;
`endif

endmodule

// File: tb/tb_binary_multiplier_4bit.sv
// Self-checking bench for binary_multiplier_4bit: directed and random products
// compared against plain integer multiplication.
module tb_binary_multiplier_4bit;

  logic       clock = 1'b0;
  logic       reset_b;
  logic       Start;
  logic [3:0] Multiplicand;
  logic [3:0] Multiplier;
  logic [7:0] Product;
  logic       Ready;
  logic       done_w;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  binary_multiplier_4bit dut (
    .clock        (clock),
    .reset_b      (reset_b),
    .Start        (Start),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Product      (Product),
    .Ready        (Ready)
`ifdef MULT_DONE_PULSE_EN
    ,
    .Done         (done_w)
`endif
  );

`ifndef MULT_DONE_PULSE_EN
  assign done_w = 1'b0;
`endif

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_done(input string tag, input logic exp);
`ifdef MULT_DONE_PULSE_EN
    check(tag, {7'd0, done_w}, {7'd0, exp});
`endif
  endtask

  // One multiplication from idle with a single Start pulse; reference is a*b.
  task automatic run_mult(input logic [3:0] mc, input logic [3:0] mp);
    int expv;
    expv = int'(mc) * int'(mp);
    Start = 1'b1; Multiplicand = mc; Multiplier = mp;
    @(negedge clock);
    Start = 1'b0; Multiplicand = 4'($urandom); Multiplier = 4'($urandom);
    check("busy_e0", {7'd0, Ready}, 8'd0);
    for (int i = 1; i < 8; i++) begin
      @(negedge clock);
      check("busy", {7'd0, Ready}, 8'd0);
    end
    @(negedge clock);
    check("ready_end", {7'd0, Ready}, 8'd1);
    check("product", Product, 8'(expv));
    check_done("done_pulse", 1'b1);
    @(negedge clock);
    check("product_hold", Product, 8'(expv));
    check("ready_hold", {7'd0, Ready}, 8'd1);
    check_done("done_clear", 1'b0);
  endtask

  initial begin
    reset_b = 1'b0; Start = 1'b0; Multiplicand = 4'd0; Multiplier = 4'd0;
    @(negedge clock);
    @(negedge clock);
    check("reset_product", Product, 8'h00);
    check("reset_ready", {7'd0, Ready}, 8'd1);
    check_done("reset_done", 1'b0);
    reset_b = 1'b1;
    @(negedge clock);

    run_mult(4'd8, 4'd1);
    run_mult(4'd15, 4'd15);
    run_mult(4'd13, 4'd11);
    run_mult(4'd0, 4'd9);
    for (int r = 0; r < 10; r++) begin
      run_mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Start while busy must be ignored.
    Start = 1'b1; Multiplicand = 4'd15; Multiplier = 4'd15;
    @(negedge clock);
    Start = 1'b0;
    for (int i = 1; i < 4; i++) @(negedge clock);
    Start = 1'b1; Multiplicand = 4'd3; Multiplier = 4'd3;
    @(negedge clock);
    Start = 1'b0;
    check("busy_ignore_ready", {7'd0, Ready}, 8'd0);
    for (int i = 5; i <= 8; i++) @(negedge clock);
    check("ignore_product", Product, 8'hE1);
    check("ignore_ready", {7'd0, Ready}, 8'd1);
    @(negedge clock);
    check("no_restart", {7'd0, Ready}, 8'd1);
    check("no_restart_product", Product, 8'hE1);

    // Reset in the middle of an operation.
    Start = 1'b1; Multiplicand = 4'd13; Multiplier = 4'd11;
    @(negedge clock);
    Start = 1'b0;
    for (int i = 1; i <= 4; i++) @(negedge clock);
    reset_b = 1'b0;
    @(negedge clock);
    check("midreset_product", Product, 8'h00);
    check("midreset_ready", {7'd0, Ready}, 8'd1);
    check_done("midreset_done", 1'b0);
    reset_b = 1'b1;
    @(negedge clock);
    run_mult(4'd2, 4'd3);

    // Back-to-back with Start held high.
    Start = 1'b1; Multiplicand = 4'd5; Multiplier = 4'd7;
    @(negedge clock);
    Multiplicand = 4'd6; Multiplier = 4'd9;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clock);
      check("b2b_busy1", {7'd0, Ready}, 8'd0);
    end
    @(negedge clock);
    check("b2b_ready1", {7'd0, Ready}, 8'd1);
    check("b2b_product1", Product, 8'd35);
    check_done("b2b_done1", 1'b1);
    @(negedge clock);
    Start = 1'b0;
    check("b2b_accept2", {7'd0, Ready}, 8'd0);
    check_done("b2b_done1_clear", 1'b0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clock);
      check("b2b_busy2", {7'd0, Ready}, 8'd0);
    end
    @(negedge clock);
    check("b2b_ready2", {7'd0, Ready}, 8'd1);
    check("b2b_product2", Product, 8'd54);
    check_done("b2b_done2", 1'b1);
    @(negedge clock);
    check_done("b2b_done2_clear", 1'b0);
    check("b2b_idle", {7'd0, Ready}, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
